riscv_alu_decoder: RTL and testbench

Decode stage that produces the control word consumed by riscv_alu. It accepts raw RV32I instructions plus PC over a valid/ready handshake, then emits the ALU opcode, operand selects, immediate and register indices. Output is registered, and a 2-entry skid buffer sustains one instruction per cycle under backpressure. It sits between fetch and the register-read/ALU stage.

---
 rtl/riscv_alu_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_riscv_alu_decoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_alu_decoder.sv
// RV32I decode stage producing the riscv_alu control word, with a registered output and a 2-entry skid buffer.
// Optional build macro ALU_DEC_ILLEGAL_TRAP_EN: propagate illegal instructions flagged instead of squashing them to NOPs.
module riscv_alu_decoder #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic [1:0]      out_a_sel,
  output logic            out_use_imm,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  localparam logic [3:0] ALU_ADD     = 4'd0;
  localparam logic [3:0] ALU_SUB     = 4'd1;
  localparam logic [3:0] ALU_SHIFTL  = 4'd2;
  localparam logic [3:0] ALU_SLT     = 4'd3;
  localparam logic [3:0] ALU_SLTU    = 4'd4;
  localparam logic [3:0] ALU_XOR     = 4'd5;
  localparam logic [3:0] ALU_SHIFTR  = 4'd6;
  localparam logic [3:0] ALU_SHIFTRA = 4'd7;
  localparam logic [3:0] ALU_OR      = 4'd8;
  localparam logic [3:0] ALU_AND     = 4'd9;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]      alu_op;
    logic [1:0]      a_sel;
    logic            use_imm;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_we;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } word_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  word_t      dec;
  word_t      o_word;
  word_t      s_word;
  logic       o_valid;
  logic       s_valid;
  logic       accept;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  always_comb begin
    legal       = 1'b0;
    dec         = '0;
    dec.pc      = in_pc;
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.rd      = in_instr[11:7];
    dec.alu_op  = ALU_ADD;
    dec.a_sel   = A_RS1;
    unique case (opcode)
      OPC_OP_IMM: begin
        dec.use_imm = 1'b1;
        dec.imm     = XLEN'($signed(in_instr[31:20]));
        legal       = 1'b1;
        unique case (funct3)
          3'b000: dec.alu_op = ALU_ADD;
          3'b010: dec.alu_op = ALU_SLT;
          3'b011: dec.alu_op = ALU_SLTU;
          3'b100: dec.alu_op = ALU_XOR;
          3'b110: dec.alu_op = ALU_OR;
          3'b111: dec.alu_op = ALU_AND;
          3'b001: begin
            dec.alu_op = ALU_SHIFTL;
            dec.imm    = XLEN'(in_instr[24:20]);
            legal      = (funct7 == F7_BASE);
          end
          default: begin
            dec.imm = XLEN'(in_instr[24:20]);
            if (funct7 == F7_BASE)     dec.alu_op = ALU_SHIFTR;
            else if (funct7 == F7_ALT) dec.alu_op = ALU_SHIFTRA;
            else                       legal      = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
          unique case (funct3)
            3'b000:  dec.alu_op = ALU_ADD;
            3'b001:  dec.alu_op = ALU_SHIFTL;
            3'b010:  dec.alu_op = ALU_SLT;
            3'b011:  dec.alu_op = ALU_SLTU;
            3'b100:  dec.alu_op = ALU_XOR;
            3'b101:  dec.alu_op = ALU_SHIFTR;
            3'b110:  dec.alu_op = ALU_OR;
            default: dec.alu_op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            dec.alu_op = ALU_SUB;
            legal      = 1'b1;
          end else if (funct3 == 3'b101) begin
            dec.alu_op = ALU_SHIFTRA;
            legal      = 1'b1;
          end
        end
      end
      OPC_LUI: begin
        dec.a_sel   = A_ZERO;
        dec.use_imm = 1'b1;
        dec.imm     = XLEN'($signed({in_instr[31:12], 12'b0}));
        legal       = 1'b1;
      end
      OPC_AUIPC: begin
        dec.a_sel   = A_PC;
        dec.use_imm = 1'b1;
        dec.imm     = XLEN'($signed({in_instr[31:12], 12'b0}));
        legal       = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    dec.rd_we = legal && (dec.rd != 5'd0);

    if (!legal) begin
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
      dec.alu_op  = ALU_ADD;
      dec.rd_we   = 1'b0;
      dec.illegal = 1'b1;
`else
      // Squash to a harmless write-nothing ADD so downstream never sees the bad word.
      dec.alu_op  = ALU_ADD;
      dec.a_sel   = A_ZERO;
      dec.use_imm = 1'b1;
      dec.imm     = '0;
      dec.rd      = 5'd0;
      dec.rd_we   = 1'b0;
      dec.illegal = 1'b0;
`endif
    end
  end

  // in_ready is the inverted skid flop, so no combinational path from out_ready.
  assign in_ready = !s_valid;
  assign accept   = in_valid && !s_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      s_valid <= 1'b0;
      o_word  <= '0;
      o_word.pc <= RESET_PC;
      s_word  <= '0;
    end else if (flush) begin
      o_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!o_valid || out_ready) begin
      if (s_valid) begin
        o_word  <= s_word;
        o_valid <= 1'b1;
        s_valid <= 1'b0;
      end else if (accept) begin
        o_word  <= dec;
        o_valid <= 1'b1;
      end else begin
        o_valid <= 1'b0;
      end
    end else if (accept) begin
      s_word  <= dec;
      s_valid <= 1'b1;
    end
  end

  assign out_valid   = o_valid;
  assign out_alu_op  = o_word.alu_op;
  assign out_a_sel   = o_word.a_sel;
  assign out_use_imm = o_word.use_imm;
  assign out_imm     = o_word.imm;
  assign out_rs1     = o_word.rs1;
  assign out_rs2     = o_word.rs2;
  assign out_rd      = o_word.rd;
  assign out_rd_we   = o_word.rd_we;
  assign out_pc      = o_word.pc;
  assign out_illegal = o_word.illegal;

endmodule

// File: tb/tb_riscv_alu_decoder.sv
// Directed self-checking bench for riscv_alu_decoder; honours ALU_DEC_ILLEGAL_TRAP_EN when defined.
module tb_riscv_alu_decoder;

  localparam logic [31:0] RST_PC = 32'h0000_0080;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SRA = 4'd7;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [3:0]  out_alu_op;
  logic [1:0]  out_a_sel;
  logic        out_use_imm, out_rd_we, out_illegal;
  logic [31:0] out_imm, out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;

  int n_cmp = 0;
  int n_fail = 0;

  riscv_alu_decoder #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_a_sel(out_a_sel), .out_use_imm(out_use_imm),
    .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // Offer one word with out_ready high; returns at the negedge where it sits in O.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    @(negedge clk);
    in_valid = 1'b1; in_instr = instr; in_pc = pc; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; in_instr = 32'h00510093; in_pc = 32'h44;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
    n_cmp++; if (out_pc !== RST_PC) begin n_fail++; $display("FAIL rst_pc got %0h want %0h", out_pc, RST_PC); end
    n_cmp++; if (out_imm !== 32'h0) begin n_fail++; $display("FAIL rst_imm got %0h want 0", out_imm); end
    n_cmp++; if (out_rd !== 5'd0 || out_rd_we !== 1'b0) begin n_fail++; $display("FAIL rst_rd got %0d/%0b want 0/0", out_rd, out_rd_we); end
    n_cmp++; if (out_alu_op !== 4'd0 || out_illegal !== 1'b0) begin n_fail++; $display("FAIL rst_op got %0d/%0b want 0/0", out_alu_op, out_illegal); end
  endtask

  task automatic test_op_imm;
    send(32'h00510093, 32'h10);  // addi x1,x2,5
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %0b want 1", out_valid); end
    n_cmp++; if (out_alu_op !== OP_ADD) begin n_fail++; $display("FAIL addi_op got %0d want %0d", out_alu_op, OP_ADD); end
    n_cmp++; if (out_use_imm !== 1'b1 || out_a_sel !== 2'd0) begin n_fail++; $display("FAIL addi_sel got %0b/%0d want 1/0", out_use_imm, out_a_sel); end
    n_cmp++; if (out_imm !== 32'd5) begin n_fail++; $display("FAIL addi_imm got %0h want 5", out_imm); end
    n_cmp++; if (out_rs1 !== 5'd2 || out_rd !== 5'd1 || out_rd_we !== 1'b1) begin n_fail++; $display("FAIL addi_regs got %0d/%0d/%0b want 2/1/1", out_rs1, out_rd, out_rd_we); end
    n_cmp++; if (out_pc !== 32'h10) begin n_fail++; $display("FAIL addi_pc got %0h want 10", out_pc); end
    send(32'h40315093, 32'h14);  // srai x1,x2,3
    n_cmp++; if (out_alu_op !== OP_SRA) begin n_fail++; $display("FAIL srai_op got %0d want %0d", out_alu_op, OP_SRA); end
    n_cmp++; if (out_imm !== 32'd3 || out_use_imm !== 1'b1) begin n_fail++; $display("FAIL srai_imm got %0h/%0b want 3/1", out_imm, out_use_imm); end
    send(32'hFFF10093, 32'h18);  // addi x1,x2,-1
    n_cmp++; if (out_imm !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL addi_neg_imm got %0h want ffffffff", out_imm); end
    send(32'h00100013, 32'h1C);  // addi x0,x0,1
    n_cmp++; if (out_rd_we !== 1'b0 || out_illegal !== 1'b0) begin n_fail++; $display("FAIL rd0_we got %0b/%0b want 0/0", out_rd_we, out_illegal); end
  endtask

  task automatic test_op;
    send(32'h405201B3, 32'h20);  // sub x3,x4,x5
    n_cmp++; if (out_alu_op !== OP_SUB) begin n_fail++; $display("FAIL sub_op got %0d want %0d", out_alu_op, OP_SUB); end
    n_cmp++; if (out_use_imm !== 1'b0) begin n_fail++; $display("FAIL sub_use_imm got %0b want 0", out_use_imm); end
    n_cmp++; if (out_rs1 !== 5'd4 || out_rs2 !== 5'd5 || out_rd !== 5'd3) begin n_fail++; $display("FAIL sub_regs got %0d/%0d/%0d want 4/5/3", out_rs1, out_rs2, out_rd); end
    n_cmp++; if (out_rd_we !== 1'b1) begin n_fail++; $display("FAIL sub_we got %0b want 1", out_rd_we); end
  endtask

  task automatic test_upper;
    send(32'h123450B7, 32'h40);  // lui x1,0x12345
    n_cmp++; if (out_alu_op !== OP_ADD || out_a_sel !== 2'd2) begin n_fail++; $display("FAIL lui_op got %0d/%0d want 0/2", out_alu_op, out_a_sel); end
    n_cmp++; if (out_imm !== 32'h12345000 || out_use_imm !== 1'b1) begin n_fail++; $display("FAIL lui_imm got %0h/%0b want 12345000/1", out_imm, out_use_imm); end
    send(32'h12345097, 32'h100); // auipc x1,0x12345
    n_cmp++; if (out_a_sel !== 2'd1) begin n_fail++; $display("FAIL auipc_sel got %0d want 1", out_a_sel); end
    n_cmp++; if (out_pc !== 32'h100) begin n_fail++; $display("FAIL auipc_pc got %0h want 100", out_pc); end
    n_cmp++; if (out_imm !== 32'h12345000 || out_rd !== 5'd1) begin n_fail++; $display("FAIL auipc_imm got %0h/%0d want 12345000/1", out_imm, out_rd); end
  endtask

  task automatic test_illegal;
    logic [31:0] words [2];
    words = '{32'h40311093, 32'h00000000};
    for (int i = 0; i < 2; i++) begin
      send(words[i], 32'h200);
      n_cmp++; if (out_valid !== 1'b1 || out_rd_we !== 1'b0 || out_alu_op !== OP_ADD) begin n_fail++; $display("FAIL ill%0d_base got v%0b we%0b op%0d want v1 we0 op0", i, out_valid, out_rd_we, out_alu_op); end
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
      n_cmp++; if (out_illegal !== 1'b1) begin n_fail++; $display("FAIL ill%0d_flag got %0b want 1", i, out_illegal); end
`else
      n_cmp++; if (out_illegal !== 1'b0 || out_rd !== 5'd0) begin n_fail++; $display("FAIL ill%0d_nop got ill%0b rd%0d want 0/0", i, out_illegal, out_rd); end
      n_cmp++; if (out_a_sel !== 2'd2 || out_use_imm !== 1'b1 || out_imm !== 32'h0) begin n_fail++; $display("FAIL ill%0d_nop_ops got %0d/%0b/%0h want 2/1/0", i, out_a_sel, out_use_imm, out_imm); end
`endif
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vec [4];
    int sent, rx;
    vec = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
    sent = 0; rx = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      out_ready = (c == 0 || c >= 6);
      in_valid  = (sent < 4);
      in_instr  = (sent < 4) ? vec[sent] : 32'h0;
      in_pc     = 32'h300 + 32'(sent * 4);
      if (c == 2) begin
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_full got rdy%0b v%0b want 0/1", in_ready, out_valid); end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_cmp++;
        if (rx >= 4 || out_rd !== 5'(rx + 1) || out_imm !== 32'(rx + 1)) begin
          n_fail++; $display("FAIL b2b_word%0d got rd%0d imm%0h want rd%0d imm%0h", rx, out_rd, out_imm, rx + 1, rx + 1);
        end
        rx++;
      end
      if (in_valid && in_ready === 1'b1) sent++;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (rx != 4 || sent != 4) begin n_fail++; $display("FAIL b2b_count got rx%0d tx%0d want 4/4", rx, sent); end
  endtask

  task automatic fill_both;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h400;
    @(posedge clk);
    @(negedge clk);
    in_instr = 32'h00600113; in_pc = 32'h404;
    @(posedge clk);
    @(negedge clk);
    in_instr = 32'h00700193; in_pc = 32'h408;
  endtask

  task automatic test_flush;
    int leaks;
    fill_both();
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre got rdy%0b v%0b want 0/1", in_ready, out_valid); end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_post got v%0b rdy%0b want 0/1", out_valid, in_ready); end
    // Flush with the skid empty: in_ready reads 1 but the offered word is dropped.
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00800213; out_ready = 1'b1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_rdy got %0b want 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    leaks = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid !== 1'b0) leaks++;
      @(negedge clk);
    end
    n_cmp++; if (leaks != 0) begin n_fail++; $display("FAIL flush_leak got %0d want 0", leaks); end
  endtask

  task automatic test_reset_midstream;
    int leaks;
    fill_both();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== RST_PC) begin n_fail++; $display("FAIL midrst got v%0b rdy%0b pc%0h want 0/1/%0h", out_valid, in_ready, out_pc, RST_PC); end
    out_ready = 1'b1;
    leaks = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) leaks++;
    end
    n_cmp++; if (leaks != 0) begin n_fail++; $display("FAIL midrst_leak got %0d want 0", leaks); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    test_reset();
    test_op_imm();
    test_op();
    test_upper();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
